countdown_timer_core: RTL and testbench
=======================================

// Module: countdown_timer_core
// PURPOSE
// - MM:SS BCD countdown core for the stopwatch. Four digit registers step down once per second.
// - Borrow cascade: sec units mod 10, sec tens mod 6, min units mod 10, min tens mod 10.
// - Holds the run/pause/done state machine and the 1 Hz prescaler.
// - Digit outputs drive the 7-seg decoder/mux stage downstream.
// PARAMETERS
// - TICK_DIV  50_000_000  clk cycles per 1 s tick; must be >=2
// - PW        26          prescaler width; 2**PW >= TICK_DIV
// PORTS
// - clk        in   1  single system clock, rising edge
// - rst        in   1  asynchronous, active-high reset
// - start      in   1  level, sampled each edge; start/resume
// - pause      in   1  level, sampled each edge; pause a running count
// - clear      in   1  level, sampled each edge; go to IDLE and zero all digits
// - load       in   1  level, sampled each edge; load the preset digits
// - ld_min_t   in   4  preset minutes tens (BCD)
// - ld_min_u   in   4  preset minutes units (BCD)
// - ld_sec_t   in   4  preset seconds tens (BCD)
// - ld_sec_u   in   4  preset seconds units (BCD)
// - min_t      out  4  minutes tens digit
// - min_u      out  4  minutes units digit
// - sec_t      out  4  seconds tens digit
// - sec_u      out  4  seconds units digit
// - running    out  1  high while in RUN
// - done       out  1  countdown reached 00:00
// - tick       out  1  one-cycle pulse on the edge where the digits decrement
// BEHAVIOUR
// - Reset (async): all digits 0, running=0, done=0, tick=0, prescaler=0, state=IDLE.
// - All outputs are registered.
// - States: IDLE, RUN, PAUSED, DONE.
// - Command priority each edge: clear > load > pause > start.
// - clear (any state): digits=0, prescaler=0, state IDLE, done=0.
// - load: honoured only in IDLE, PAUSED or DONE; ignored in RUN.
//   - Digits take the presets; state IDLE; prescaler=0; done=0.
//   - Clamping: a units digit >9 becomes 9; a sec tens digit >5 becomes 5; min tens >9 becomes 9.
// - start:
//   - IDLE with nonzero digits: go to RUN, prescaler=0, running=1 on the next cycle.
//   - IDLE with digits 00:00: ignored.
//   - PAUSED: go to RUN; the prescaler resumes from its held value.
// - pause in RUN: go to PAUSED; digits and prescaler hold.
// - RUN:
//   - Prescaler counts 0..TICK_DIV-1.
//   - At TICK_DIV-1 it wraps to 0, tick=1 for one cycle, and the digits decrement at that same edge.
//   - The first decrement lands exactly TICK_DIV cycles after the start edge.
// - Borrow cascade:
//   - sec_u 0->9 borrows from sec_t.
//   - sec_t 0->5 borrows from min_u.
//   - min_u 0->9 borrows from min_t.
//   - No wrap past 00:00.
// - A decrement that produces 00:00 goes to DONE in the same edge: running=0, done=1, digits 00:00.
// - DONE: digits hold at 00:00. Leave only via clear or load. start is ignored.
// - rst mid-run: immediate return to the reset values. No partial tick.
// CONFIGURATION
// - COUNTDOWN_AUTORELOAD_EN defined:
//   - The core keeps a shadow copy of the last loaded (clamped) preset.
//   - On reaching 00:00 it reloads the shadow, stays in RUN, and done pulses for exactly 1 cycle.
//   - A zero shadow goes to DONE as in the default behaviour.
// - COUNTDOWN_AUTORELOAD_EN undefined:
//   - No shadow register. Behaviour is DONE-state as specified above; done stays high (level).
// TESTING (TICK_DIV=4)
// - rst pulse mid-count -> all digits 0, running=0, done=0, tick=0 immediately (asynchronous).
// - load 00:12, start -> running=1 next cycle; 00:11 4 cycles after the start edge; 00:10; then 00:09.
// - load 10:00, start, one tick -> 09:59 (borrow through all four digits).
// - load 00:01, start -> after 4 cycles 00:00, done=1, running=0; further starts ignored.
//   - With COUNTDOWN_AUTORELOAD_EN: digits return to 00:01, done high 1 cycle, running stays 1.
// - 00:05 running, pause after 2 prescaler counts, hold 10 cycles -> digits frozen.
//   - Then start: the next tick arrives 2 cycles later.
// - load ld_sec_u=0xC, ld_sec_t=7, ld_min_t=0xF -> digits 90:59 (clamped). load while in RUN -> no change.

Source files
------------

// File: rtl/countdown_timer_core.sv
`default_nettype none
// =====================================================================
// Module   : countdown_timer_core
// Brief    : MM:SS BCD countdown with run/pause/done control and a 1 Hz
//            prescaler. Define COUNTDOWN_AUTORELOAD_EN to reload the last
//            preset on expiry instead of stopping in DONE.
// Revision : 1.0 - initial release
// =====================================================================
module countdown_timer_core #(
   parameter int TICK_DIV = 50_000_000,
   parameter int PW       = 26
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       pause,
   input  logic       clear,
   input  logic       load,
   input  logic [3:0] ld_min_t,
   input  logic [3:0] ld_min_u,
   input  logic [3:0] ld_sec_t,
   input  logic [3:0] ld_sec_u,
   output logic [3:0] min_t,
   output logic [3:0] min_u,
   output logic [3:0] sec_t,
   output logic [3:0] sec_u,
   output logic       running,
   output logic       done,
   output logic       tick
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [PW-1:0] C_PRESC_LAST = PW'(TICK_DIV - 1);

   state_t        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [15:0]   digits_q, digits_d;   // {min_t, min_u, sec_t, sec_u}
   logic          running_q, running_d;
   logic          done_q, done_d;
   logic          tick_q, tick_d;

   logic [15:0]   w_preset;
   logic [15:0]   w_dec;
   logic          w_cur_zero;
   logic          w_dec_zero;

`ifdef COUNTDOWN_AUTORELOAD_EN
   logic [15:0]   shadow_q, shadow_d;
   logic          w_reload;
`endif

   assign w_preset = {(ld_min_t > 4'd9) ? 4'd9 : ld_min_t,
                      (ld_min_u > 4'd9) ? 4'd9 : ld_min_u,
                      (ld_sec_t > 4'd5) ? 4'd5 : ld_sec_t,
                      (ld_sec_u > 4'd9) ? 4'd9 : ld_sec_u};

   assign w_cur_zero = (digits_q == 16'h0000);
   assign w_dec_zero = (w_dec == 16'h0000);

   // One-second decrement with the borrow cascade; saturates at 00:00.
   always_comb begin
      w_dec = digits_q;
      if (w_cur_zero) begin
         w_dec = 16'h0000;
      end else if (digits_q[3:0] != 4'd0) begin
         w_dec[3:0] = digits_q[3:0] - 4'd1;
      end else begin
         w_dec[3:0] = 4'd9;
         if (digits_q[7:4] != 4'd0) begin
            w_dec[7:4] = digits_q[7:4] - 4'd1;
         end else begin
            w_dec[7:4] = 4'd5;
            if (digits_q[11:8] != 4'd0) begin
               w_dec[11:8] = digits_q[11:8] - 4'd1;
            end else begin
               w_dec[11:8]  = 4'd9;
               w_dec[15:12] = digits_q[15:12] - 4'd1;
            end
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      presc_d  = presc_q;
      digits_d = digits_q;
      tick_d   = 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
      shadow_d = shadow_q;
      w_reload = 1'b0;
`endif
      if (clear) begin
         digits_d = 16'h0000;
         presc_d  = '0;
         state_d  = IDLE;
      end else if (load && (state_q != RUN)) begin
         digits_d = w_preset;
         presc_d  = '0;
         state_d  = IDLE;
`ifdef COUNTDOWN_AUTORELOAD_EN
         shadow_d = w_preset;
`endif
      end else if (pause) begin
         // pause outranks start, so it also blocks a resume while held
         if (state_q == RUN) begin
            state_d = PAUSED;
         end
      end else if (start && (state_q == IDLE) && !w_cur_zero) begin
         state_d = RUN;
         presc_d = '0;
      end else if (start && (state_q == PAUSED)) begin
         state_d = RUN;
      end else if (state_q == RUN) begin
         if (presc_q == C_PRESC_LAST) begin
            presc_d  = '0;
            tick_d   = 1'b1;
            digits_d = w_dec;
            if (w_dec_zero) begin
`ifdef COUNTDOWN_AUTORELOAD_EN
               if (shadow_q != 16'h0000) begin
                  digits_d = shadow_q;
                  w_reload = 1'b1;
               end else begin
                  state_d = DONE;
               end
`else
               state_d = DONE;
`endif
            end
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end

      running_d = (state_d == RUN);
`ifdef COUNTDOWN_AUTORELOAD_EN
      done_d    = (state_d == DONE) || w_reload;
`else
      done_d    = (state_d == DONE);
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         presc_q   <= '0;
         digits_q  <= 16'h0000;
         running_q <= 1'b0;
         done_q    <= 1'b0;
         tick_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         digits_q  <= digits_d;
         running_q <= running_d;
         done_q    <= done_d;
         tick_q    <= tick_d;
      end
   end

`ifdef COUNTDOWN_AUTORELOAD_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_q <= 16'h0000;
      end else begin
         shadow_q <= shadow_d;
      end
   end
`endif

   assign min_t   = digits_q[15:12];
   assign min_u   = digits_q[11:8];
   assign sec_t   = digits_q[7:4];
   assign sec_u   = digits_q[3:0];
   assign running = running_q;
   assign done    = done_q;
   assign tick    = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer_core.sv
`default_nettype none
// =====================================================================
// Module   : tb_countdown_timer_core
// Brief    : Self-checking bench for countdown_timer_core (TICK_DIV=4),
//            compared against a seconds-count reference model.
// Revision : 1.0 - initial release
// =====================================================================
module tb_countdown_timer_core;

   localparam int TICK_DIV = 4;
   localparam int PW       = 3;

   localparam int M_IDLE   = 0;
   localparam int M_RUN    = 1;
   localparam int M_PAUSED = 2;
   localparam int M_DONE   = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0, pause = 1'b0, clear = 1'b0, load = 1'b0;
   logic [3:0] ld_min_t = 4'd0, ld_min_u = 4'd0, ld_sec_t = 4'd0, ld_sec_u = 4'd0;
   logic [3:0] min_t, min_u, sec_t, sec_u;
   logic       running, done, tick;

   int checks = 0;
   int errors = 0;

   // Reference model: remaining time as plain seconds.
   int   m_total, m_mode, m_phase, m_shadow;
   logic m_done, m_tick;

   countdown_timer_core #(.TICK_DIV(TICK_DIV), .PW(PW)) dut (
      .clk(clk), .rst(rst),
      .start(start), .pause(pause), .clear(clear), .load(load),
      .ld_min_t(ld_min_t), .ld_min_u(ld_min_u), .ld_sec_t(ld_sec_t), .ld_sec_u(ld_sec_u),
      .min_t(min_t), .min_u(min_u), .sec_t(sec_t), .sec_u(sec_u),
      .running(running), .done(done), .tick(tick)
   );

   always #5 clk = ~clk;

   function automatic int clampv(input logic [3:0] v, input int lim);
      return (int'(v) > lim) ? lim : int'(v);
   endfunction

   function automatic int preset_total();
      return (clampv(ld_min_t, 9) * 10 + clampv(ld_min_u, 9)) * 60
             + clampv(ld_sec_t, 5) * 10 + clampv(ld_sec_u, 9);
   endfunction

   task automatic model_reset();
      m_total = 0; m_mode = M_IDLE; m_phase = 0; m_shadow = 0;
      m_done = 1'b0; m_tick = 1'b0;
   endtask

   task automatic model_step();
      logic pulse;
      pulse  = 1'b0;
      m_tick = 1'b0;
      if (clear) begin
         m_total = 0; m_phase = 0; m_mode = M_IDLE;
      end else if (load && m_mode != M_RUN) begin
         m_total = preset_total(); m_shadow = m_total; m_mode = M_IDLE; m_phase = 0;
      end else if (pause) begin
         if (m_mode == M_RUN) m_mode = M_PAUSED;
      end else if (start && m_mode == M_IDLE && m_total != 0) begin
         m_mode = M_RUN; m_phase = 0;
      end else if (start && m_mode == M_PAUSED) begin
         m_mode = M_RUN;
      end else if (m_mode == M_RUN) begin
         if (m_phase == TICK_DIV - 1) begin
            m_phase = 0;
            m_tick  = 1'b1;
            m_total = m_total - 1;
            if (m_total == 0) begin
`ifdef COUNTDOWN_AUTORELOAD_EN
               if (m_shadow != 0) begin
                  m_total = m_shadow; pulse = 1'b1;
               end else begin
                  m_mode = M_DONE;
               end
`else
               m_mode = M_DONE;
`endif
            end
         end else begin
            m_phase = m_phase + 1;
         end
      end
      m_done = (m_mode == M_DONE) || pulse;
   endtask

   function automatic logic [18:0] dut_vec();
      return {min_t, min_u, sec_t, sec_u, running, done, tick};
   endfunction

   function automatic logic [18:0] exp_vec();
      int mins, secs;
      mins = m_total / 60;
      secs = m_total % 60;
      return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10),
              (m_mode == M_RUN), m_done, m_tick};
   endfunction

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic load_preset(input logic [3:0] mt, mu, st, su);
      ld_min_t = mt; ld_min_u = mu; ld_sec_t = st; ld_sec_u = su;
      load = 1'b1; cyc(); load = 1'b0;
   endtask

   task automatic press_start();
      start = 1'b1; cyc(); start = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1; cyc(); clear = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; #12;
      model_reset();
      checks++;
      if (dut_vec() !== 19'd0) begin
         errors++; $display("FAIL reset_values got %h exp %h", dut_vec(), 19'd0);
      end
      @(negedge clk); rst = 1'b0;
      cyc();
      checks++;
      if (dut_vec() !== exp_vec()) begin
         errors++; $display("FAIL reset_release got %h exp %h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_countdown();
      logic [15:0] steps [3];
      steps[0] = 16'h0011; steps[1] = 16'h0010; steps[2] = 16'h0009;
      do_clear();
      load_preset(4'd0, 4'd0, 4'd1, 4'd2);
      press_start();
      checks++;
      if ({running, min_t, min_u, sec_t, sec_u} !== {1'b1, 16'h0012}) begin
         errors++; $display("FAIL start_running got %b/%h exp 1/0012", running, {min_t, min_u, sec_t, sec_u});
      end
      for (int k = 1; k <= 12; k++) begin
         cyc();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL countdown_model k=%0d got %h exp %h", k, dut_vec(), exp_vec());
         end
         if (k % 4 == 0) begin
            checks++;
            if ({min_t, min_u, sec_t, sec_u, tick} !== {steps[k/4-1], 1'b1}) begin
               errors++; $display("FAIL countdown_step k=%0d got %h/%b exp %h/1", k,
                                  {min_t, min_u, sec_t, sec_u}, tick, steps[k/4-1]);
            end
         end
      end
   endtask

   task automatic test_borrow();
      do_clear();
      load_preset(4'd1, 4'd0, 4'd0, 4'd0);
      press_start();
      for (int k = 0; k < 4; k++) cyc();
      checks++;
      if ({min_t, min_u, sec_t, sec_u, tick} !== {16'h0959, 1'b1}) begin
         errors++; $display("FAIL borrow_0959 got %h/%b exp 0959/1", {min_t, min_u, sec_t, sec_u}, tick);
      end
      checks++;
      if (dut_vec() !== exp_vec()) begin
         errors++; $display("FAIL borrow_model got %h exp %h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_done();
      do_clear();
      load_preset(4'd0, 4'd0, 4'd0, 4'd1);
      press_start();
      for (int k = 0; k < 4; k++) cyc();
`ifdef COUNTDOWN_AUTORELOAD_EN
      checks++;
      if ({min_t, min_u, sec_t, sec_u, running, done} !== {16'h0001, 1'b1, 1'b1}) begin
         errors++; $display("FAIL reload_hit got %h exp %h", dut_vec(), {16'h0001, 3'b111});
      end
      cyc();
      checks++;
      if ({running, done} !== 2'b10) begin
         errors++; $display("FAIL reload_pulse got %b%b exp 10", running, done);
      end
`else
      checks++;
      if ({min_t, min_u, sec_t, sec_u, running, done} !== {16'h0000, 1'b0, 1'b1}) begin
         errors++; $display("FAIL done_hit got %h exp %h", dut_vec(), {16'h0000, 3'b011});
      end
      start = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cyc();
         checks++;
         if ({running, done, min_t, min_u, sec_t, sec_u} !== {2'b01, 16'h0000} || dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL done_start_ignored got %h exp %h", dut_vec(), exp_vec());
         end
      end
      start = 1'b0;
`endif
   endtask

   task automatic test_pause();
      do_clear();
      load_preset(4'd0, 4'd0, 4'd0, 4'd5);
      press_start();
      cyc(); cyc();
      pause = 1'b1; cyc(); pause = 1'b0;
      for (int k = 0; k < 10; k++) begin
         cyc();
         checks++;
         if ({min_t, min_u, sec_t, sec_u, running, tick} !== {16'h0005, 2'b00} || dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL pause_hold k=%0d got %h exp %h", k, dut_vec(), exp_vec());
         end
      end
      press_start();
      cyc();
      checks++;
      if ({running, tick} !== 2'b10) begin
         errors++; $display("FAIL resume_early got %b%b exp 10", running, tick);
      end
      cyc();
      checks++;
      if ({min_t, min_u, sec_t, sec_u, tick} !== {16'h0004, 1'b1}) begin
         errors++; $display("FAIL resume_tick got %h/%b exp 0004/1", {min_t, min_u, sec_t, sec_u}, tick);
      end
   endtask

   task automatic test_clamp();
      do_clear();
      load_preset(4'hF, 4'd0, 4'd7, 4'hC);
      checks++;
      if ({min_t, min_u, sec_t, sec_u} !== 16'h9059) begin
         errors++; $display("FAIL clamp got %h exp 9059", {min_t, min_u, sec_t, sec_u});
      end
      press_start();
      cyc();
      load_preset(4'd1, 4'd2, 4'd3, 4'd4);
      checks++;
      if ({min_t, min_u, sec_t, sec_u, running} !== {16'h9059, 1'b1}) begin
         errors++; $display("FAIL load_in_run got %h/%b exp 9059/1", {min_t, min_u, sec_t, sec_u}, running);
      end
      cyc(); cyc();
      checks++;
      if ({min_t, min_u, sec_t, sec_u, tick} !== {16'h9058, 1'b1} || dut_vec() !== exp_vec()) begin
         errors++; $display("FAIL clamp_tick got %h exp %h", dut_vec(), exp_vec());
      end
      do_clear();
      checks++;
      if (dut_vec() !== 19'd0) begin
         errors++; $display("FAIL clear got %h exp 0", dut_vec());
      end
   endtask

   task automatic test_async_reset();
      do_clear();
      load_preset(4'd0, 4'd0, 4'd1, 4'd2);
      press_start();
      cyc(); cyc();
      #3; rst = 1'b1; #1;
      model_reset();
      checks++;
      if (dut_vec() !== 19'd0) begin
         errors++; $display("FAIL async_reset got %h exp 0", dut_vec());
      end
      #2; rst = 1'b0;
      cyc();
      checks++;
      if (dut_vec() !== exp_vec()) begin
         errors++; $display("FAIL async_release got %h exp %h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 3000; k++) begin
         clear = ($urandom_range(63) == 0);
         load  = ($urandom_range(15) == 0);
         pause = ($urandom_range(15) == 0);
         start = ($urandom_range(7) == 0);
         ld_min_t = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'd0;
         ld_min_u = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'd0;
         ld_sec_t = ($urandom_range(2) == 0) ? 4'($urandom_range(15)) : 4'd0;
         ld_sec_u = 4'($urandom_range(15));
         cyc();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL random k=%0d got %h exp %h", k, dut_vec(), exp_vec());
         end
      end
      clear = 1'b0; load = 1'b0; pause = 1'b0; start = 1'b0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_countdown();
      test_borrow();
      test_done();
      test_pause();
      test_clamp();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
